// File: rtl/audio_pkg.sv
// Shared types and default sizes for the audio serial path.
// Used by audio_serializer and by the bit-clock edge detector.
package audio_pkg;

    // Default PCM width per channel and bit-clock periods per channel slot
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_SLOT_W = 32;

    // Serializer frame position: waiting for the first sample, or inside a slot
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/audio_serializer_bclk_edge_det.sv
// Bit-clock edge detector: registers the divided bit clock in the system
// clock domain and flags the single clk cycle of each rising/falling edge.
// The receive path will reuse the rise output.
module bclk_edge_det
    import audio_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_bclk,
    output logic o_rise,
    output logic o_fall
);

    logic r_bclk_q;

    // Delay the bit clock by one clk so edges can be seen as level changes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bclk_q <= 1'b0;
        end else begin
            r_bclk_q <= i_bclk;
        end
    end

    assign o_rise = ~r_bclk_q & i_bclk;
    assign o_fall = r_bclk_q & ~i_bclk;

endmodule

// File: rtl/audio_serializer.sv
// audio_serializer: serialises stereo PCM samples to a codec, MSB first,
// shifting on each falling edge of the divided bit clock and driving LRCLK
// (0 = left slot, 1 = right slot). Samples enter through a one-entry
// valid/ready buffer; a frame that starts with that buffer empty sends zeros
// and pulses underrun.
// Optional build macro I2S_ONE_BIT_DELAY_EN: adds one bit-clock of delay on
// the serial data (Philips I2S). Left undefined, timing is left-justified.
module audio_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int SLOT_W = DEFAULT_SLOT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk_in,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sdata_out,
    output logic              lrclk_out,
    output logic              frame_start,
    output logic              underrun
);

    localparam int               CNT_W    = $clog2(SLOT_W);
    localparam int               PAD_W    = SLOT_W - DATA_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_W - 1);

    logic              w_fall;
    logic              w_unused_bclk_rise;
    logic              w_write;
    logic              w_slot_end;
    logic              w_frame_boundary;
    logic              w_drain;
    logic [SLOT_W-1:0] w_load_l;
    logic [SLOT_W-1:0] w_load_r;

    logic              r_buf_full;
    logic [DATA_W-1:0] r_buf_l;
    logic [DATA_W-1:0] r_buf_r;
    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [SLOT_W-1:0] r_shift_l;
    logic [SLOT_W-1:0] r_shift_r;
    logic              r_sdata;
    logic              r_lrclk;
    logic              r_frame_start;
    logic              r_underrun;

    bclk_edge_det u_edge (
        .i_clk   (clk),
        .i_reset (reset),
        .i_bclk  (bclk_in),
        .o_rise  (w_unused_bclk_rise),
        .o_fall  (w_fall)
    );

    // Samples are left-aligned in the slot; bits beyond DATA_W go out as zero
    assign w_load_l = SLOT_W'(r_buf_l) << PAD_W;
    assign w_load_r = SLOT_W'(r_buf_r) << PAD_W;

    assign w_write          = sample_valid & ~r_buf_full;
    assign w_slot_end       = (r_bit_cnt == LAST_BIT);
    assign w_frame_boundary = w_fall & ((r_state == IDLE) | ((r_state == RIGHT) & w_slot_end));
    assign w_drain          = w_frame_boundary & r_buf_full;

    // One-entry sample buffer; ready is low while full so a write and a drain never meet
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else if (w_write) begin
            r_buf_full <= 1'b1;
            r_buf_l    <= l_data;
            r_buf_r    <= r_data;
        end else if (w_drain) begin
            r_buf_full <= 1'b0;
        end
    end

    // Frame sequencer: loads frames, shifts bits and toggles LRCLK on bit-clock falls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift_l     <= '0;
            r_shift_r     <= '0;
            r_sdata       <= 1'b0;
            r_lrclk       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (r_buf_full) begin
                            r_shift_l     <= w_load_l;
                            r_shift_r     <= w_load_r;
                            r_sdata       <= w_load_l[SLOT_W-1];
                            r_lrclk       <= 1'b0;
                            r_bit_cnt     <= '0;
                            r_frame_start <= 1'b1;
                            r_state       <= LEFT;
                        end else begin
                            r_sdata <= 1'b0;
                        end
                    end
                    LEFT: begin
                        if (w_slot_end) begin
                            r_lrclk   <= 1'b1;
                            r_bit_cnt <= '0;
                            r_sdata   <= r_shift_r[SLOT_W-1];
                            r_state   <= RIGHT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_sdata   <= r_shift_l[SLOT_W-2];
                            r_shift_l <= r_shift_l << 1;
                        end
                    end
                    RIGHT: begin
                        if (w_slot_end) begin
                            r_lrclk   <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= LEFT;
                            if (r_buf_full) begin
                                r_shift_l     <= w_load_l;
                                r_shift_r     <= w_load_r;
                                r_sdata       <= w_load_l[SLOT_W-1];
                                r_frame_start <= 1'b1;
                            end else begin
                                r_shift_l  <= '0;
                                r_shift_r  <= '0;
                                r_sdata    <= 1'b0;
                                r_underrun <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_sdata   <= r_shift_r[SLOT_W-2];
                            r_shift_r <= r_shift_r << 1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef I2S_ONE_BIT_DELAY_EN
    logic r_sdata_dly;

    // Hold each bit for one extra bit-clock so the MSB trails the LRCLK edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sdata_dly <= 1'b0;
        end else if (w_fall) begin
            r_sdata_dly <= r_sdata;
        end
    end

    assign sdata_out = r_sdata_dly;
`else
    assign sdata_out = r_sdata;
`endif

    assign sample_ready = ~r_buf_full;
    assign lrclk_out    = r_lrclk;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_serializer.sv
// Bench for audio_serializer with an 8-clk bit clock, DATA_W=16, SLOT_W=32.
// A frame-position model predicts every output on every clk; a few literal
// frame patterns and pulse counts pin the model itself.
module tb_audio_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bclk_in = 1'b0;
    logic [15:0] l_data = '0;
    logic [15:0] r_data = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        sdata_out;
    logic        lrclk_out;
    logic        frame_start;
    logic        underrun;

    int checks = 0;
    int failures = 0;
    int fallCount = 0;
    int fsCount = 0;
    int urCount = 0;
    bit feedOn = 1'b0;
    bit ok;
    logic [63:0] frameBits;

    // Model state: buffer, frame position 0..63 and the 64-bit frame word
    bit          mPrevBclk = 1'b0;
    bit          mBufFull = 1'b0;
    logic [15:0] mBufL = '0;
    logic [15:0] mBufR = '0;
    bit          mStarted = 1'b0;
    int          mPos = 0;
    logic [63:0] mFrame = '0;
    bit          mPrevBit = 1'b0;
    logic        mExpSdata = 1'b0;
    logic        mExpLr = 1'b0;
    logic        mExpFs = 1'b0;
    logic        mExpUr = 1'b0;

    audio_serializer #(.DATA_W(16), .SLOT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk_in      (bclk_in),
        .l_data       (l_data),
        .r_data       (r_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sdata_out    (sdata_out),
        .lrclk_out    (lrclk_out),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Divided bit clock: 4 clk high, 4 clk low, changed just after posedge
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            bclk_in = (phase < 4);
            phase = (phase + 1) % 8;
        end
    end

    // Safety net against a hung bench
    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b want %b", name, $time, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s timed out at %0t", name, $time);
    endtask

    // Frame model: every bit-clock fall advances one position in a 64-bit frame
    task automatic modelStep();
        bit fall;
        bit readyOld;
        bit newBit;
        if (reset) begin
            mPrevBclk = 1'b0; mBufFull = 1'b0; mStarted = 1'b0; mPos = 0; mFrame = '0;
            mPrevBit = 1'b0; mExpSdata = 1'b0; mExpLr = 1'b0; mExpFs = 1'b0; mExpUr = 1'b0;
            return;
        end
        readyOld = !mBufFull;
        fall = mPrevBclk && !bclk_in;
        mPrevBclk = bclk_in;
        mExpFs = 1'b0;
        mExpUr = 1'b0;
        if (fall) begin
            fallCount++;
            if (!mStarted) begin
                if (mBufFull) begin
                    mStarted = 1'b1;
                    mPos = 0;
                    mFrame = {mBufL, 16'h0000, mBufR, 16'h0000};
                    mBufFull = 1'b0;
                    mExpFs = 1'b1;
                end
            end else begin
                mPos = (mPos + 1) % 64;
                if (mPos == 0) begin
                    if (mBufFull) begin
                        mFrame = {mBufL, 16'h0000, mBufR, 16'h0000};
                        mBufFull = 1'b0;
                        mExpFs = 1'b1;
                    end else begin
                        mFrame = '0;
                        mExpUr = 1'b1;
                    end
                end
            end
            newBit = mStarted ? mFrame[63 - mPos] : 1'b0;
            mExpLr = mStarted && (mPos >= 32);
`ifdef I2S_ONE_BIT_DELAY_EN
            mExpSdata = mPrevBit;
            mPrevBit = newBit;
`else
            mExpSdata = newBit;
`endif
        end
        if (sample_valid && readyOld) begin
            mBufFull = 1'b1;
            mBufL = l_data;
            mBufR = r_data;
        end
    endtask

    // Advance the model on every clock edge and on reset assertion
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            modelStep();
        end
    end

    // Compare all outputs to the model on every falling clk edge outside reset
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                checkBit("sample_ready", sample_ready, !mBufFull);
                checkBit("sdata_out", sdata_out, mExpSdata);
                checkBit("lrclk_out", lrclk_out, mExpLr);
                checkBit("frame_start", frame_start, mExpFs);
                checkBit("underrun", underrun, mExpUr);
                if (frame_start === 1'b1) fsCount++;
                if (underrun === 1'b1) urCount++;
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, output bit done);
        @(posedge clk);
        #1;
        l_data = l;
        r_data = r;
        sample_valid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (sample_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        sample_valid = 1'b0;
        if (!done) failTimeout("applyStimulus");
    endtask

    task automatic waitFrameStart(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        if (!seen) failTimeout("waitFrameStart");
    endtask

    task automatic waitFalls(input int count);
        int target;
        target = fallCount + count;
        for (int n = 0; n < count * 8 + 64 && fallCount < target; n++) begin
            @(negedge clk);
        end
        if (fallCount < target) failTimeout("waitFalls");
    endtask

    // Record the 64 sdata bits of a frame, starting at its frame_start pulse
    task automatic captureFrame(output logic [63:0] bits);
        bit seen;
        int idx;
        int last;
        bits = '0;
        waitFrameStart(seen);
        if (!seen) return;
        bits[63] = sdata_out;
        idx = 62;
        last = fallCount;
        for (int n = 0; n < 1000 && idx >= 0; n++) begin
            @(negedge clk);
            if (fallCount != last) begin
                last = fallCount;
                bits[idx] = sdata_out;
                idx--;
            end
        end
        if (idx >= 0) failTimeout("captureFrame");
    endtask

    task automatic feeder();
        logic [15:0] feedData;
        feedData = 16'h1000;
        l_data = feedData;
        r_data = ~feedData;
        sample_valid = 1'b1;
        while (feedOn) begin
            @(negedge clk);
            if (sample_ready) begin
                @(posedge clk);
                #1;
                feedData = feedData + 16'h1357;
                l_data = feedData;
                r_data = ~feedData;
            end
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] expT1;
        logic [63:0] expT5;
        logic [63:0] expT6;
`ifdef I2S_ONE_BIT_DELAY_EN
        expT1 = 64'h52F8_0000_0787_8000;
        expT5 = 64'h4000_0000_0000_0000;
        expT6 = 64'h1999_8000_2222_0000;
`else
        expT1 = 64'hA5F0_0000_0F0F_0000;
        expT5 = 64'h8000_0000_0000_0000;
        expT6 = 64'h3333_0000_4444_0000;
`endif

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBit("rst_ready", sample_ready, 1'b1);
        checkBit("rst_sdata", sdata_out, 1'b0);
        checkBit("rst_lrclk", lrclk_out, 1'b0);
        checkBit("rst_frame_start", frame_start, 1'b0);
        checkBit("rst_underrun", underrun, 1'b0);
        #2;
        reset = 1'b0;

        // Test 1: single frame A5F0 / 0F0F
        $display("[TB] test 1: basic frame");
        applyStimulus(16'hA5F0, 16'h0F0F, ok);
        @(negedge clk);
        checkBit("t1_ready_low_after_accept", sample_ready, 1'b0);
        captureFrame(frameBits);
        checkOutput("t1_frame_bits", frameBits, expT1);

        // Test 3: nothing supplied, next frame is zeros with one underrun
        $display("[TB] test 3: underrun");
        @(posedge clk);
        fsCount = 0;
        urCount = 0;
        waitFalls(64);
        @(posedge clk);
        checkCount("t3_underrun_pulses", urCount, 1);
        checkCount("t3_frame_start_pulses", fsCount, 0);

        // Test 4: asynchronous reset in the middle of the left slot
        $display("[TB] test 4: reset mid-frame");
        doReset();
        applyStimulus(16'hA5F0, 16'h0F0F, ok);
        waitFrameStart(ok);
        waitFalls(10);
        #2;
        reset = 1'b1;
        #1;
        checkBit("t4_async_sdata", sdata_out, 1'b0);
        checkBit("t4_async_lrclk", lrclk_out, 1'b0);
        checkBit("t4_async_ready", sample_ready, 1'b1);
        checkBit("t4_async_frame_start", frame_start, 1'b0);
        checkBit("t4_async_underrun", underrun, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        fsCount = 0;
        urCount = 0;
        waitFalls(20);
        @(posedge clk);
        checkCount("t4_idle_frame_starts", fsCount, 0);
        checkCount("t4_idle_underruns", urCount, 0);
        applyStimulus(16'hA5F0, 16'h0F0F, ok);
        captureFrame(frameBits);
        checkOutput("t4_restart_frame_bits", frameBits, expT1);

        // Test 2: back-to-back samples, one frame per 64 falls
        $display("[TB] test 2: streaming");
        doReset();
        feedOn = 1'b1;
        fork
            feeder();
        join_none
        waitFrameStart(ok);
        @(posedge clk);
        fsCount = 0;
        urCount = 0;
        waitFalls(192);
        @(posedge clk);
        checkCount("t2_frame_starts", fsCount, 3);
        checkCount("t2_underruns", urCount, 0);
        feedOn = 1'b0;
        repeat (4) @(posedge clk);

        // Test 6: valid held high while the buffer is full
        $display("[TB] test 6: hold while full");
        doReset();
        @(posedge clk);
        #1;
        l_data = 16'h1111;
        r_data = 16'h2222;
        sample_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (!sample_ready) ok = 1'b1;
        end
        if (!ok) failTimeout("t6_first_accept");
        l_data = 16'h3333;
        r_data = 16'h4444;
        waitFrameStart(ok);
        checkBit("t6_ready_after_drain", sample_ready, 1'b1);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        checkBit("t6_ready_after_refill", sample_ready, 1'b0);
        captureFrame(frameBits);
        checkOutput("t6_second_frame_bits", frameBits, expT6);

        // Test 5: single MSB marks where the slot's first bit lands
        $display("[TB] test 5: MSB position");
        doReset();
        applyStimulus(16'h8000, 16'h0000, ok);
        captureFrame(frameBits);
        checkOutput("t5_frame_bits", frameBits, expT5);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
